// File: rtl/atm_terminal_arbiter.sv
// atm_terminal_arbiter
//   Shares one ATM transaction core between N_TERM terminals. Requests are
//   arbitrated round-robin; the winner's fields are latched onto the core
//   inputs, the core is released from reset for TXN_CYCLES cycles, and the
//   resulting balance/success are returned with a one-cycle done pulse.
//   Between transactions the core is held in reset, which returns it to idle.
//
// Optional feature macro: ATM_FAIL_LOCKOUT_EN
//   Defined   : per-account saturating fail counters; an account is locked
//               after FAIL_LIMIT consecutive failures, until reset.
//   Undefined : no counters, locked is tied to zero.
//
// Ports
//   clk, rst                    clock (rising edge), async active-low reset
//   req                         per-terminal request level
//   t_operation/acc_num/pin/    per-terminal transaction fields, terminal i
//   new_pin/amount/language     in slice [W*i +: W]
//   gnt                         one-hot grant, held for the whole transaction
//   done                        one-hot, one-cycle completion pulse
//   rsp_balance, rsp_success    result, valid while done != 0
//   locked                      bit a-1 set = account a locked
//   atm_rst                     active-low run enable to the core
//   atm_operation..atm_language latched transaction fields to the core
//   atm_balance, atm_success    core results
//   atm_state                   core state, not used for control
//
// state  | meaning
// S_IDLE | waiting for any req; pick winner, latch fields
// S_RUN  | core running (atm_rst=1) for TXN_CYCLES cycles
// S_DONE | done pulse, grant held, core flushed (atm_rst=0)

module atm_terminal_arbiter #(
    parameter int N_TERM     = 4,
    parameter int N_ACC      = 10,
    parameter int TXN_CYCLES = 4,
    parameter int FAIL_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_TERM-1:0]    req,
    input  logic [3*N_TERM-1:0]  t_operation,
    input  logic [4*N_TERM-1:0]  t_acc_num,
    input  logic [16*N_TERM-1:0] t_pin,
    input  logic [16*N_TERM-1:0] t_new_pin,
    input  logic [32*N_TERM-1:0] t_amount,
    input  logic [N_TERM-1:0]    t_language,
    output logic [N_TERM-1:0]    gnt,
    output logic [N_TERM-1:0]    done,
    output logic [31:0]          rsp_balance,
    output logic                 rsp_success,
    output logic [N_ACC-1:0]     locked,
    output logic                 atm_rst,
    output logic [2:0]           atm_operation,
    output logic [3:0]           atm_acc_num,
    output logic [15:0]          atm_pin,
    output logic [15:0]          atm_new_pin,
    output logic [31:0]          atm_amount,
    output logic                 atm_language,
    input  logic [31:0]          atm_balance,
    input  logic                 atm_success,
    input  logic [2:0]           atm_state
);

    localparam int PTR_W = (N_TERM > 1) ? $clog2(N_TERM) : 1;
    localparam int CNT_W = (TXN_CYCLES > 1) ? $clog2(TXN_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_found;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [N_TERM-1:0]  w_win_oh;
    int                 w_idx;
    logic [2:0]         w_op;
    logic [3:0]         w_acc;
    logic               w_acc_ok;
    logic               w_lock_hit;
    logic               w_valid;
    logic               w_unused;

    // First set request at or after the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int i = 0; i < N_TERM; i++) begin
            w_idx = (int'(r_ptr) + i) % N_TERM;
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = PTR_W'(w_idx);
            end
        end
    end

    assign w_win_oh  = N_TERM'(1) << w_win;
    assign w_ptr_nxt = (int'(w_win) == N_TERM - 1) ? '0 : w_win + 1'b1;
    assign w_op      = t_operation[3*int'(w_win) +: 3];
    assign w_acc     = t_acc_num[4*int'(w_win) +: 4];
    assign w_acc_ok  = (w_acc != 4'd0) && (int'(w_acc) <= N_ACC);

`ifdef ATM_FAIL_LOCKOUT_EN
    logic [1:0]  r_fail_cnt [N_ACC];
    logic [3:0]  w_cur_idx;
    logic [15:0] w_lock_by_acc;

    // Shifted by one so the account number indexes it directly.
    assign w_lock_by_acc = 16'({locked, 1'b0});
    assign w_lock_hit    = w_lock_by_acc[w_acc];
    assign w_cur_idx     = atm_acc_num - 4'd1;
    assign w_unused      = ^atm_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            locked <= '0;
            for (int a = 0; a < N_ACC; a++) r_fail_cnt[a] <= '0;
        end else if (r_state == S_RUN && r_cnt == '0) begin
            if (atm_success) begin
                r_fail_cnt[w_cur_idx] <= '0;
            end else begin
                if (r_fail_cnt[w_cur_idx] != 2'd3)
                    r_fail_cnt[w_cur_idx] <= r_fail_cnt[w_cur_idx] + 2'd1;
                if (int'(r_fail_cnt[w_cur_idx]) + 1 >= FAIL_LIMIT)
                    locked[w_cur_idx] <= 1'b1;
            end
        end
    end
`else
    assign locked     = '0;
    assign w_lock_hit = 1'b0;
    assign w_unused   = ^atm_state ^ (FAIL_LIMIT == 0);
`endif

    assign w_valid = (w_op >= 3'd3) && (w_op <= 3'd6) && w_acc_ok && !w_lock_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_cnt         <= '0;
            gnt           <= '0;
            done          <= '0;
            rsp_balance   <= '0;
            rsp_success   <= 1'b0;
            atm_rst       <= 1'b0;
            atm_operation <= '0;
            atm_acc_num   <= '0;
            atm_pin       <= '0;
            atm_new_pin   <= '0;
            atm_amount    <= '0;
            atm_language  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        gnt           <= w_win_oh;
                        r_ptr         <= w_ptr_nxt;
                        atm_operation <= w_op;
                        atm_acc_num   <= w_acc;
                        atm_pin       <= t_pin[16*int'(w_win) +: 16];
                        atm_new_pin   <= t_new_pin[16*int'(w_win) +: 16];
                        atm_amount    <= t_amount[32*int'(w_win) +: 32];
                        atm_language  <= t_language[w_win];
                        if (w_valid) begin
                            r_state <= S_RUN;
                            atm_rst <= 1'b1;
                            r_cnt   <= CNT_W'(TXN_CYCLES - 1);
                        end else begin
                            // Rejected without touching the core.
                            r_state     <= S_DONE;
                            done        <= w_win_oh;
                            rsp_balance <= '0;
                            rsp_success <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (r_cnt == '0) begin
                        rsp_balance <= atm_balance;
                        rsp_success <= atm_success;
                        atm_rst     <= 1'b0;
                        done        <= gnt;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    done    <= '0;
                    gnt     <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_terminal_arbiter.sv
module tb_atm_terminal_arbiter;

    localparam int N_TERM = 4;
    localparam int N_ACC  = 10;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_TERM-1:0]    req;
    logic [3*N_TERM-1:0]  t_operation;
    logic [4*N_TERM-1:0]  t_acc_num;
    logic [16*N_TERM-1:0] t_pin;
    logic [16*N_TERM-1:0] t_new_pin;
    logic [32*N_TERM-1:0] t_amount;
    logic [N_TERM-1:0]    t_language;
    logic [N_TERM-1:0]    gnt;
    logic [N_TERM-1:0]    done;
    logic [31:0]          rsp_balance;
    logic                 rsp_success;
    logic [N_ACC-1:0]     locked;
    logic                 atm_rst;
    logic [2:0]           atm_operation;
    logic [3:0]           atm_acc_num;
    logic [15:0]          atm_pin;
    logic [15:0]          atm_new_pin;
    logic [31:0]          atm_amount;
    logic                 atm_language;
    logic [31:0]          atm_balance;
    logic                 atm_success;
    logic [2:0]           atm_state;

    int n_err = 0;
    int n_chk = 0;
    logic [31:0] bal [16];

    always #5 clk = ~clk;

    atm_terminal_arbiter dut (
        .clk(clk), .rst(rst), .req(req),
        .t_operation(t_operation), .t_acc_num(t_acc_num), .t_pin(t_pin),
        .t_new_pin(t_new_pin), .t_amount(t_amount), .t_language(t_language),
        .gnt(gnt), .done(done), .rsp_balance(rsp_balance), .rsp_success(rsp_success),
        .locked(locked), .atm_rst(atm_rst), .atm_operation(atm_operation),
        .atm_acc_num(atm_acc_num), .atm_pin(atm_pin), .atm_new_pin(atm_new_pin),
        .atm_amount(atm_amount), .atm_language(atm_language),
        .atm_balance(atm_balance), .atm_success(atm_success), .atm_state(atm_state)
    );

    // Simple ATM core: every account's PIN is 1234, balance held in bal[].
    always_comb begin
        atm_state   = atm_rst ? 3'd1 : 3'd7;
        atm_success = 1'b0;
        atm_balance = '0;
        if (atm_rst && atm_pin == 16'd1234 && atm_acc_num >= 4'd1 && atm_acc_num <= 4'd10) begin
            atm_success = 1'b1;
            case (atm_operation)
                3'd4:    atm_balance = bal[atm_acc_num] - atm_amount;
                3'd5:    atm_balance = bal[atm_acc_num] + atm_amount;
                default: atm_balance = bal[atm_acc_num];
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic set_term(input int t, input logic [2:0] op, input logic [3:0] acc,
                            input logic [15:0] pin, input logic [31:0] amt);
        t_operation[3*t +: 3] = op;
        t_acc_num[4*t +: 4]   = acc;
        t_pin[16*t +: 16]     = pin;
        t_new_pin[16*t +: 16] = 16'd0;
        t_amount[32*t +: 32]  = amt;
        t_language[t]         = 1'b0;
    endtask

    // Called just after a rising edge with the arbiter idle.
    task automatic run_txn(input int t, input logic [2:0] op, input logic [3:0] acc,
                           input logic [15:0] pin, input logic [31:0] amt,
                           input logic [31:0] exp_bal, input logic exp_succ,
                           input logic valid, input logic drop_early);
        int c;
        int eng;
        set_term(t, op, acc, pin, amt);
        req[t] = 1'b1;
        @(posedge clk); #1;
        chk("gnt", 32'(gnt), 32'(1 << t));
        chk("atm_acc_num", 32'(atm_acc_num), 32'(acc));
        if (drop_early) req[t] = 1'b0;
        c = 1;
        eng = 0;
        while (done == '0 && c < 20) begin
            if (atm_rst) eng++;
            @(posedge clk); #1;
            c++;
        end
        chk("latency", 32'(c), valid ? 32'd5 : 32'd1);
        chk("done", 32'(done), 32'(1 << t));
        chk("rsp_balance", rsp_balance, exp_bal);
        chk("rsp_success", 32'(rsp_success), 32'(exp_succ));
        chk("engaged_cycles", 32'(eng), valid ? 32'd4 : 32'd0);
        chk("atm_rst_in_done", 32'(atm_rst), 32'd0);
        chk("gnt_held", 32'(gnt), 32'(1 << t));
        req[t] = 1'b0;
        if (exp_succ && op == 3'd5) bal[acc] = bal[acc] + amt;
        if (exp_succ && op == 3'd4) bal[acc] = bal[acc] - amt;
        @(posedge clk); #1;
        chk("gnt_clear", 32'(gnt), 32'd0);
        chk("done_clear", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        for (int i = 0; i < 16; i++) bal[i] = 32'(i * 1000);
        rst = 1'b0;
        req = '0;
        t_operation = '0; t_acc_num = '0; t_pin = '0;
        t_new_pin = '0; t_amount = '0; t_language = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_balance", rsp_balance, 32'd0);
        chk("rst_success", 32'(rsp_success), 32'd0);
        chk("rst_atm_rst", 32'(atm_rst), 32'd0);
        chk("rst_atm_fields", 32'({atm_operation, atm_acc_num, atm_language}), 32'd0);
        chk("rst_atm_pin_amt", atm_amount ^ 32'(atm_pin), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Contention: all four at once, pointer starts at 0.
        for (int t = 0; t < N_TERM; t++) set_term(t, 3'd3, 4'(t + 1), 16'd1234, 32'd0);
        req = 4'b1111;
        @(posedge clk); #1;
        for (int t = 0; t < N_TERM; t++) begin
            c = 0;
            while (done == '0 && c < 20) begin
                @(posedge clk); #1;
                c++;
            end
            chk("cont_done", 32'(done), 32'(1 << t));
            chk("cont_balance", rsp_balance, 32'((t + 1) * 1000));
            chk("cont_atm_rst", 32'(atm_rst), 32'd0);
            req[t] = 1'b0;
            @(posedge clk); #1;
        end

        // Single op.
        run_txn(0, 3'd3, 4'd1, 16'd1234, 32'd0, 32'd1000, 1'b1, 1'b1, 1'b0);

        // Invalid: bad op, acc 0, acc 11.
        run_txn(1, 3'd7, 4'd1,  16'd1234, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        run_txn(1, 3'd3, 4'd0,  16'd1234, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        run_txn(1, 3'd3, 4'd11, 16'd1234, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Deposit (req dropped right after grant), then withdraw.
        run_txn(2, 3'd5, 4'd2, 16'd1234, 32'd1000, 32'd3000, 1'b1, 1'b1, 1'b1);
        run_txn(2, 3'd4, 4'd2, 16'd1234, 32'd500,  32'd2500, 1'b1, 1'b1, 1'b0);

        // Reset in RUN cycle 2.
        set_term(3, 3'd3, 4'd3, 16'd1234, 32'd0);
        req[3] = 1'b1;
        @(posedge clk); #1;
        chk("mid_gnt", 32'(gnt), 32'd8);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'd0);
        chk("mid_rst_atm_rst", 32'(atm_rst), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        req[3] = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", 32'(done), 32'd0);
        run_txn(3, 3'd3, 4'd3, 16'd1234, 32'd0, 32'd3000, 1'b1, 1'b1, 1'b0);

        // Three wrong-PIN attempts on account 1, then the right PIN.
        for (int k = 0; k < 3; k++)
            run_txn(0, 3'd3, 4'd1, 16'd1235, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
`ifdef ATM_FAIL_LOCKOUT_EN
        chk("locked_after_fails", 32'(locked), 32'h1);
        run_txn(0, 3'd3, 4'd1, 16'd1234, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
`else
        chk("locked_after_fails", 32'(locked), 32'h0);
        run_txn(0, 3'd3, 4'd1, 16'd1234, 32'd0, 32'd1000, 1'b1, 1'b1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
